// File: rtl/sumador_restador_secuencial.sv
// Sequential N-bit two's-complement adder/subtractor.
// A K-bit ripple-carry slice processes one chunk per clock, least-significant
// chunk first, with the inter-chunk carry kept in a register. The result
// becomes visible on Sum only when the last chunk has been processed, and
// listo pulses for that single cycle.
module sumador_restador_secuencial #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         M,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C0,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         V,
    output logic         Z,
    output logic         listo,
    output logic         ocupado
);

    localparam int P  = N / K;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(P - 1);
    localparam logic [K-1:0]  ONES_K     = '1;
    localparam logic [N-1:0]  CHUNK_MASK = N'(ONES_K);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUMA = 2'd1,
        FIN  = 2'd2
    } state_t;

    // K-bit ripple-carry slice; returns {carry out, carry into MSB, sum bits}.
    // The carry into the MSB is needed for the signed-overflow flag.
    function automatic logic [K+1:0] ripple_chunk(
        input logic [K-1:0] a,
        input logic [K-1:0] b,
        input logic         cin
    );
        logic [K-1:0] s;
        logic         c;
        logic         c_msb;
        s     = '0;
        c     = cin;
        c_msb = cin;
        for (int i = 0; i < K; i++) begin
            c_msb = c;
            s[i]  = a[i] ^ b[i] ^ c;
            c     = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        return {c, c_msb, s};
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [N-1:0]    a_q,     a_d;
    logic [N-1:0]    b_q,     b_d;
    logic            c_q,     c_d;
    logic [N-1:0]    acc_q,   acc_d;
    logic [N-1:0]    sum_q,   sum_d;
    logic            cout_q,  cout_d;
    logic            v_q,     v_d;

    logic [K-1:0]    a_chunk_s;
    logic [K-1:0]    b_chunk_s;
    logic [K+1:0]    slice_s;
    int              chunk_lsb_s;

    // Next-state logic: operand capture on accept, one chunk per SUMA cycle,
    // result publication on the last chunk.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        v_d         = v_q;
        chunk_lsb_s = K * int'(cnt_q);
        a_chunk_s   = K'(a_q >> chunk_lsb_s);
        b_chunk_s   = K'(b_q >> chunk_lsb_s);
        slice_s     = ripple_chunk(a_chunk_s, b_chunk_s, c_q);

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    // Subtraction is A + ~B + ~C0, so B is inverted and the
                    // borrow-in becomes an inverted carry-in.
                    a_d     = A;
                    b_d     = B ^ {N{M}};
                    c_d     = C0 ^ M;
                    cnt_d   = '0;
                    state_d = SUMA;
                end else begin
                    state_d = IDLE;
                end
            end
            SUMA: begin
                acc_d = (acc_q & ~(CHUNK_MASK << chunk_lsb_s))
                      | (N'(slice_s[K-1:0]) << chunk_lsb_s);
                c_d   = slice_s[K+1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CHUNK) begin
                    sum_d   = acc_d;
                    cout_d  = slice_s[K+1];
                    v_d     = slice_s[K+1] ^ slice_s[K];
                    cnt_d   = '0;
                    state_d = FIN;
                end else begin
                    state_d = SUMA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign Sum     = sum_q;
    assign Cout    = cout_q;
    assign V       = v_q;
    assign Z       = (sum_q == {N{1'b0}});
    assign listo   = (state_q == FIN);
    assign ocupado = (state_q == SUMA);

endmodule

// File: tb/tb_sumador_restador_secuencial.sv
// Bench for sumador_restador_secuencial: three 8-bit instances (K = 4, 8, 1)
// share stimulus. A cycle-level behavioural model tracks each instance and is
// compared every cycle; directed cases pin literal results and latencies.
module tb_sumador_restador_secuencial;

    logic       clk;
    logic       rst;
    logic       start;
    logic       m_in;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       c0_in;

    logic [7:0] sum_w   [3];
    logic       cout_w  [3];
    logic       v_w     [3];
    logic       z_w     [3];
    logic       listo_w [3];
    logic       ocu_w   [3];

    int PK [3] = '{2, 1, 8};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KG = (g == 0) ? 4 : ((g == 1) ? 8 : 1);
        sumador_restador_secuencial #(.N(8), .K(KG)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .M       (m_in),
            .A       (a_in),
            .B       (b_in),
            .C0      (c0_in),
            .Sum     (sum_w[g]),
            .Cout    (cout_w[g]),
            .V       (v_w[g]),
            .Z       (z_w[g]),
            .listo   (listo_w[g]),
            .ocupado (ocu_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {V, Cout, Sum} from integer math.
    function automatic logic [9:0] ref_calc(input logic [7:0] a, input logic [7:0] b,
                                            input logic m, input logic c0);
        int ua, ub, ures, sa, sb, sres;
        logic co, ov;
        logic [7:0] s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (m) begin
            ures = ua - ub - int'(c0);
            sres = sa - sb - int'(c0);
            co   = (ures >= 0);
        end else begin
            ures = ua + ub + int'(c0);
            sres = sa + sb + int'(c0);
            co   = (ures > 255);
        end
        ov = (sres > 127) || (sres < -128);
        s  = ures[7:0];
        return {ov, co, s};
    endfunction

    // Behavioural model state per instance.
    int         busy_m  [3];
    logic       listo_m [3];
    logic [7:0] sum_m   [3];
    logic       cout_m  [3];
    logic       v_m     [3];
    logic [9:0] pend_m  [3];

    // Model: accept when not busy, P busy cycles, then one listo cycle with results.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                busy_m[k]  <= 0;
                listo_m[k] <= 1'b0;
                sum_m[k]   <= 8'h00;
                cout_m[k]  <= 1'b0;
                v_m[k]     <= 1'b0;
            end else if (busy_m[k] > 0) begin
                busy_m[k] <= busy_m[k] - 1;
                if (busy_m[k] == 1) begin
                    listo_m[k] <= 1'b1;
                    sum_m[k]   <= pend_m[k][7:0];
                    cout_m[k]  <= pend_m[k][8];
                    v_m[k]     <= pend_m[k][9];
                end else begin
                    listo_m[k] <= 1'b0;
                end
            end else begin
                listo_m[k] <= 1'b0;
                if (start) begin
                    busy_m[k] <= PK[k];
                    pend_m[k] <= ref_calc(a_in, b_in, m_in, c0_in);
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk("sum",     k, 32'(sum_w[k]),   32'(sum_m[k]));
                chk("cout",    k, 32'(cout_w[k]),  32'(cout_m[k]));
                chk("v",       k, 32'(v_w[k]),     32'(v_m[k]));
                chk("z",       k, 32'(z_w[k]),     32'(sum_m[k] == 8'h00));
                chk("listo",   k, 32'(listo_w[k]), 32'(listo_m[k]));
                chk("ocupado", k, 32'(ocu_w[k]),   32'(busy_m[k] > 0));
            end
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        logic       c0;
        logic [7:0] s;
        logic       co;
        logic       v;
    } vec_t;

    vec_t tbl [6];

    int         first_lat [3];
    int         last_lat  [3];
    int         lcnt      [3];
    logic [7:0] fsum      [3];
    logic       fcout     [3];
    logic       fv        [3];
    logic       fz        [3];
    logic [7:0] lsum      [3];

    // Issue one operation and observe 12 cycles. mode: 0 plain, 1 disturb while
    // busy, 2 reset in the first busy cycle, 3 second op started during listo.
    task automatic run_op(input vec_t v, input int mode);
        for (int k = 0; k < 3; k++) begin
            first_lat[k] = -1;
            last_lat[k]  = -1;
            lcnt[k]      = 0;
        end
        a_in  = v.a;
        b_in  = v.b;
        m_in  = v.m;
        c0_in = v.c0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            for (int k = 0; k < 3; k++) begin
                if (listo_w[k] === 1'b1) begin
                    lcnt[k]++;
                    last_lat[k] = j;
                    lsum[k]     = sum_w[k];
                    if (first_lat[k] < 0) begin
                        first_lat[k] = j;
                        fsum[k]      = sum_w[k];
                        fcout[k]     = cout_w[k];
                        fv[k]        = v_w[k];
                        fz[k]        = z_w[k];
                    end
                end
            end
            if (mode == 1 && j == 1) begin
                a_in  = 8'($urandom);
                b_in  = 8'($urandom);
                m_in  = ~v.m;
                c0_in = ~v.c0;
                start = 1'b1;
            end
            if (mode == 1 && j == 2) start = 1'b0;
            if (mode == 2 && j == 1) rst = 1'b1;
            if (mode == 2 && j == 2) rst = 1'b0;
            if (mode == 3 && j == 3) begin
                a_in  = 8'h10;
                b_in  = 8'h20;
                m_in  = 1'b1;
                c0_in = 1'b0;
                start = 1'b1;
            end
            if (mode == 3 && j == 4) start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        tbl[0] = '{8'h3A, 8'h25, 1'b0, 1'b0, 8'h5F, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        m_in  = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        c0_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state, literal.
        for (int k = 0; k < 3; k++) begin
            chk("rst_sum",   k, 32'(sum_w[k]),   32'h0);
            chk("rst_cout",  k, 32'(cout_w[k]),  32'h0);
            chk("rst_v",     k, 32'(v_w[k]),     32'h0);
            chk("rst_z",     k, 32'(z_w[k]),     32'h1);
            chk("rst_listo", k, 32'(listo_w[k]), 32'h0);
            chk("rst_ocu",   k, 32'(ocu_w[k]),   32'h0);
        end
        @(negedge clk);

        // Directed arithmetic cases, all three slice widths.
        for (int i = 0; i < 6; i++) begin
            for (int mode = 0; mode < 2; mode++) begin
                run_op(tbl[i], mode);
                for (int k = 0; k < 3; k++) begin
                    chk("lat",     k, 32'(first_lat[k]), 32'(PK[k] + 1));
                    chk("n_listo", k, 32'(lcnt[k]),      32'h1);
                    chk("d_sum",   k, 32'(fsum[k]),      32'(tbl[i].s));
                    chk("d_cout",  k, 32'(fcout[k]),     32'(tbl[i].co));
                    chk("d_v",     k, 32'(fv[k]),        32'(tbl[i].v));
                    chk("d_z",     k, 32'(fz[k]),        32'(tbl[i].s == 8'h00));
                end
            end
        end

        // Reset in the first busy cycle aborts everything.
        run_op(tbl[0], 2);
        for (int k = 0; k < 3; k++) begin
            chk("abort_listo", k, 32'(lcnt[k]),   32'h0);
            chk("abort_sum",   k, 32'(sum_w[k]),  32'h0);
            chk("abort_cout",  k, 32'(cout_w[k]), 32'h0);
            chk("abort_v",     k, 32'(v_w[k]),    32'h0);
            chk("abort_z",     k, 32'(z_w[k]),    32'h1);
        end

        // Back-to-back: second op accepted during listo, result at t+6 for K=4.
        run_op(tbl[0], 3);
        chk("b2b_first", 0, 32'(fsum[0]),     32'h5F);
        chk("b2b_count", 0, 32'(lcnt[0]),     32'h2);
        chk("b2b_lat",   0, 32'(last_lat[0]), 32'h6);
        chk("b2b_sum",   0, 32'(lsum[0]),     32'hF0);

        // Randomized traffic, model compare only.
        for (int c = 0; c < 1500; c++) begin
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            m_in  = 1'($urandom);
            c0_in = 1'($urandom);
            start = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sumador_restador_secuencial.md
# sumador_restador_secuencial

Parametrised multi-cycle adder/subtractor: an N-bit two's-complement add or subtract is performed in N/K cycles by a K-bit ripple-carry slice, least-significant chunk first, with a registered carry between chunks. It is the sequential, width-generic successor to the team's fixed 4-bit ripple-carry adder. It provides a start/done handshake, an add/subtract mode, and carry, overflow and zero flags. It sits as the arithmetic unit behind simple datapath controllers that trade latency for area.

## Interface
- N, default 16: operand/result width in bits; N ≥ 2, N a multiple of K.
- K, default 4: slice width (bits processed per cycle); 1 ≤ K ≤ N; P = N/K chunks.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when accepting (see Operation).
- M  input  1  mode: 0 = add, 1 = subtract.
- A  input  N  operand A (two's complement or unsigned).
- B  input  N  operand B.
- C0  input  1  carry-in (add) / borrow-in (subtract).
- Sum  output  N  result, registered.
- Cout  output  1  carry out of bit N-1 (subtract: 1 = no borrow).
- V  output  1  signed overflow.
- Z  output  1  Sum == 0.
- listo  output  1  one-cycle pulse: results valid and newly updated.
- ocupado  output  1  operation in progress.

## Operation
- States: IDLE, SUMA, FIN; chunk counter cnt, width ceil(log2 P), minimum 1.
- Accept: `start=1` in IDLE or FIN.
  - Latch A into register a_r; latch B XOR {N{M}} into b_r.
  - Set carry register c_r = C0 XOR M; set cnt = 0; go to SUMA.
- Subtract result: A − B − C0. Add result: A + B + C0.
- SUMA, each edge:
  - Ripple-add chunk cnt, i.e. bits [K·cnt+K−1 : K·cnt] of a_r, b_r, with c_r.
  - Write the K sum bits into the same field of an internal sum register.
  - c_r ← chunk carry-out; cnt ← cnt+1.
  - On the edge processing chunk P−1, also capture:
    - Cout = carry out of bit N−1;
    - V = carry into bit N−1 XOR carry out of bit N−1.
  - Copy the full sum to Sum.
  - Go to FIN.
- Z is combinational from Sum.
- FIN lasts exactly one cycle; listo = 1 in FIN.
  - With no start, the next state is IDLE.
- ocupado = 1 in SUMA only.
- start in SUMA is ignored, and is not queued.
- A, B, M and C0 changes after acceptance have no effect.
- Sum, Cout and V hold their values from listo until the next completion.
- Intermediate chunk writes are not visible on Sum.
- Arithmetic is modulo 2^N. Unsigned and signed interpretation share the same bits. V is meaningful for signed operands, Cout for unsigned ones.

## Timing
- Reset, any state: next state IDLE; cnt = 0; c_r = 0.
  - Outputs after reset: Sum = 0, Cout = 0, V = 0, Z = 1, listo = 0, ocupado = 0.
  - Reset mid-operation aborts the operation; no listo is produced.
  - Reset has priority over start.
- start accepted at edge t:
  - ocupado = 1 in cycles t+1 … t+P.
  - Chunk processing happens on edges t+1 … t+P.
  - listo = 1 in cycle t+P+1, with Sum/Cout/V valid.
- Latency: P+1 cycles from the start edge to listo.
- Back-to-back operation: start = 1 during listo is accepted at that edge.
  - Throughput is one operation per P+1 cycles.
- K = N (P = 1): one SUMA cycle; listo at t+2.

## Test plan
All scenarios use N=8, K=4 unless stated.
- Reset, then idle: Sum=0x00, Cout=0, V=0, Z=1, listo=0, ocupado=0.
- Add 0x3A+0x25, C0=0, start at edge t -> ocupado in t+1..t+2; listo only in t+3; Sum=0x5F, Cout=0, V=0, Z=0.
- Add 0xFF+0x01, C0=0 -> Sum=0x00, Cout=1, V=0, Z=1.
- Add 0x7F+0x01 -> Sum=0x80, V=1, Cout=0.
- Subtract:
  - 0x10−0x20, C0=0 -> Sum=0xF0, Cout=0, V=0.
  - 0x80−0x01 -> Sum=0x7F, Cout=1, V=1.
  - 0x05−0x02, C0=1 -> Sum=0x02, Cout=1.
- Protocol checks:
  - Change A/B and pulse start while ocupado -> result unchanged, single listo.
  - rst at t+1 -> all outputs at reset values, no listo.
  - start held during listo -> second result at t+6.
  - Repeat the add cases with K=8 and K=1 -> identical results, listo at t+2 and t+9 respectively.
